// File: rtl/seg7_serial_drv.sv
// rtl/seg7_serial_drv.sv - serial frame driver for N-digit 7-segment shift-register boards
// Optional blink phase generator enabled by SEG_BLINK_EN.
module seg7_serial_drv #(
  parameter int N_DIGITS  = 8,
  parameter int CLK_DIV   = 2,
  parameter int BLINK_DIV = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic                  i_flash,
  input  logic [4*N_DIGITS-1:0] i_hexs,
  input  logic [N_DIGITS-1:0]   i_points,
  input  logic [N_DIGITS-1:0]   i_les,
  input  logic [8*N_DIGITS-1:0] i_raw,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_seg_clk,
  output logic                  o_seg_sout,
  output logic                  o_seg_pen,
  output logic                  o_seg_clrn
);

  localparam int FW = 8 * N_DIGITS;
  localparam int DW = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int BW = $clog2(FW);

  localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  logic [1:0]            r_state;
  logic [DW-1:0]         r_div;
  logic [BW-1:0]         r_bit;
  logic [FW-1:0]         r_shift;
  logic                  r_seg_clk;
  logic                  r_clrn;
  logic                  r_mode;
  logic                  r_flash;
  logic [4*N_DIGITS-1:0] r_hexs;
  logic [N_DIGITS-1:0]   r_points;
  logic [N_DIGITS-1:0]   r_les;
  logic [FW-1:0]         r_raw;
  logic [FW-1:0]         w_frame;
  logic                  w_eff_flash;

`ifdef SEG_BLINK_EN
  logic [BLINK_DIV-1:0] r_blink;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_blink <= '0;
    else        r_blink <= r_blink + 1'b1;
  end

  assign w_eff_flash = i_flash & r_blink[BLINK_DIV-1];
`else
  logic w_unused_blink;
  assign w_unused_blink = (BLINK_DIV > 0);
  assign w_eff_flash    = i_flash;
`endif

  // Active-low {g,f,e,d,c,b,a}; dp is added per digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  always_comb begin
    w_frame = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_mode)
        w_frame[8*i +: 8] = r_raw[8*i +: 8];
      else if (r_les[i] && r_flash)
        w_frame[8*i +: 8] = 8'hFF;
      else
        w_frame[8*i +: 8] = {~r_points[i], hex_to_seg(r_hexs[4*i +: 4])};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_seg_clk <= 1'b0;
      r_clrn    <= 1'b0;
      r_mode    <= 1'b0;
      r_flash   <= 1'b0;
      r_hexs    <= '0;
      r_points  <= '0;
      r_les     <= '0;
      r_raw     <= '0;
    end else begin
      r_clrn <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_mode   <= i_mode;
            r_flash  <= w_eff_flash;
            r_hexs   <= i_hexs;
            r_points <= i_points;
            r_les    <= i_les;
            r_raw    <= i_raw;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_shift   <= w_frame;
          r_div     <= '0;
          r_bit     <= '0;
          r_seg_clk <= 1'b0;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // Data changes only when seg_clk drops, so it is stable across the rising edge.
          if (r_div == DIV_LAST) begin
            r_div     <= '0;
            r_seg_clk <= 1'b0;
            r_shift   <= {r_shift[FW-2:0], 1'b0};
            if (r_bit == BIT_LAST) r_state <= ST_LATCH;
            else                   r_bit   <= r_bit + 1'b1;
          end else begin
            r_div <= r_div + 1'b1;
            if (r_div == DIV_PRE) r_seg_clk <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
  assign o_done     = (r_state == ST_LATCH);
  assign o_seg_pen  = (r_state != ST_SHIFT);
  assign o_seg_clk  = r_seg_clk;
  assign o_seg_sout = r_shift[FW-1];
  assign o_seg_clrn = r_clrn;

endmodule

// File: tb/tb_seg7_serial_drv.sv
// tb/tb_seg7_serial_drv.sv - self-checking bench for seg7_serial_drv (8 digits, CLK_DIV=2)
module tb_seg7_serial_drv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        flash = 1'b0;
  logic [31:0] hexs = '0;
  logic [7:0]  points = '0;
  logic [7:0]  les = '0;
  logic [63:0] raw = '0;
  logic        busy, done, seg_clk, seg_sout, seg_pen, seg_clrn;

  int n_assert = 0;
  int n_fail   = 0;

  seg7_serial_drv #(.N_DIGITS(8), .CLK_DIV(2), .BLINK_DIV(24)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_flash(flash),
    .i_hexs(hexs), .i_points(points), .i_les(les), .i_raw(raw),
    .o_busy(busy), .o_done(done), .o_seg_clk(seg_clk), .o_seg_sout(seg_sout),
    .o_seg_pen(seg_pen), .o_seg_clrn(seg_clrn)
  );

  always #5 clk = ~clk;

  // Board-side view: one bit taken on every seg_clk rising edge.
  logic        prev_sclk = 1'b0;
  logic [63:0] cap = '0;
  int          bitcnt = 0;
  always @(negedge clk) begin
    if (seg_clk && !prev_sclk) begin
      cap    <= {cap[62:0], seg_sout};
      bitcnt <= bitcnt + 1;
    end
    prev_sclk <= seg_clk;
  end

  function automatic logic [63:0] exp_frame(input logic m, input logic [31:0] h,
      input logic [7:0] p, input logic [7:0] l, input logic fl, input logic [63:0] r);
    logic [7:0] lut [16];
    logic [7:0] code;
    logic [63:0] f;
    lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    f = '0;
    for (int d = 0; d < 8; d++) begin
      code = lut[h[4*d +: 4]];
      if (m)                f[8*d +: 8] = r[8*d +: 8];
      else if (l[d] && fl)  f[8*d +: 8] = 8'hFF;
      else                  f[8*d +: 8] = {~p[d], code[6:0]};
    end
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one start pulse (optionally a second at restart_at) and watches 560 cycles.
  task automatic run_frame(input string tag, input int restart_at, output logic [63:0] f);
    int b0, lat, ndone;
    logic busy1, pen_mid, pen_pre, pen_lat;
    @(negedge clk);
    start = 1'b1;
    b0 = bitcnt; lat = -1; ndone = 0;
    busy1 = 1'b0; pen_mid = 1'b1; pen_pre = 1'b1; pen_lat = 1'b0;
    for (int k = 1; k <= 560; k++) begin
      @(negedge clk);
      if (k == 1)   busy1 = busy;
      if (k == 100) pen_mid = seg_pen;
      if (k == 257) pen_pre = seg_pen;
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = k; pen_lat = seg_pen; end
      end
      if (k == 1) start = 1'b0;
      if (k == restart_at) start = 1'b1;
      if (k == restart_at + 1) start = 1'b0;
    end
    f = cap;
    chk({tag, "_latency"}, 64'(lat), 64'd258);
    chk({tag, "_ndone"}, 64'(ndone), 64'd1);
    chk({tag, "_nbits"}, 64'(bitcnt - b0), 64'd64);
    chk({tag, "_busy_load"}, 64'(busy1), 64'd1);
    chk({tag, "_pen_shift"}, 64'(pen_mid & pen_pre), 64'd0);
    chk({tag, "_pen_latch"}, 64'(pen_lat), 64'd1);
  endtask

  initial begin
    logic [63:0] f;
    int b0, d1, d2, kk;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sclk", 64'(seg_clk), 64'd0);
    chk("rst_sout", 64'(seg_sout), 64'd0);
    chk("rst_pen", 64'(seg_pen), 64'd1);
    chk("rst_clrn", 64'(seg_clrn), 64'd0);
    rst = 1'b1;
    #1 chk("clrn_before_edge", 64'(seg_clrn), 64'd0);
    @(negedge clk);
    chk("clrn_after_edge", 64'(seg_clrn), 64'd1);

    // Hex frame with dp on digit 0
    mode = 1'b0; hexs = 32'h0123ABCD; points = 8'h01; les = 8'h00; flash = 1'b0;
    run_frame("hex", -10, f);
    chk("hex_const", f, 64'hC0F9A4B0_8883C621);
    chk("hex_model", f, exp_frame(1'b0, 32'h0123ABCD, 8'h01, 8'h00, 1'b0, 64'h0));

    // Blanking
    hexs = 32'h88888888; points = 8'h00; les = 8'hF0; flash = 1'b1;
    run_frame("blank", -10, f);
    chk("blank_on", f, 64'hFFFFFFFF_80808080);
    flash = 1'b0;
    run_frame("noblank", -10, f);
    chk("blank_off", f, 64'h80808080_80808080);

    // Raw mode ignores points/les/flash
    mode = 1'b1; raw = 64'h0102040810204080; points = 8'hFF; les = 8'hFF; flash = 1'b1;
    run_frame("raw", -10, f);
    chk("raw_frame", f, 64'h0102040810204080);

    // start re-asserted mid-frame is ignored; inputs changed in flight don't matter
    mode = 1'b0; hexs = 32'h76543210; points = 8'hA5; les = 8'h00; flash = 1'b0;
    fork
      begin
        repeat (3) @(negedge clk);
        hexs = 32'hFFFFFFFF; mode = 1'b1; raw = '1;
      end
      run_frame("restart", 50, f);
    join
    chk("restart_frame", f, exp_frame(1'b0, 32'h76543210, 8'hA5, 8'h00, 1'b0, 64'h0));

    // Random frames against the model
    for (int n = 0; n < 4; n++) begin
      logic [63:0] e;
      mode = 1'($urandom); hexs = $urandom; points = 8'($urandom); les = 8'($urandom);
      flash = 1'($urandom); raw = {$urandom, $urandom};
      e = exp_frame(mode, hexs, points, les, flash, raw);
      run_frame($sformatf("rnd%0d", n), -10, f);
      chk($sformatf("rnd%0d_frame", n), f, e);
    end

    // start held high: back-to-back frames
    @(negedge clk);
    start = 1'b1; d1 = -1; d2 = -1;
    for (int k = 1; k <= 700; k++) begin
      @(negedge clk);
      if (done && d1 < 0) d1 = k;
      else if (done && d2 < 0) d2 = k;
    end
    start = 1'b0;
    chk("hold_first", 64'(d1), 64'd258);
    chk("hold_spacing", 64'(d2 - d1), 64'd259);
    repeat (600) @(negedge clk);

    // Reset at bit 20, then a clean frame
    mode = 1'b0; hexs = $urandom; points = 8'($urandom); les = 8'h00; flash = 1'b0;
    @(negedge clk); start = 1'b1; b0 = bitcnt;
    @(negedge clk); start = 1'b0;
    kk = 0;
    while ((bitcnt - b0) < 20 && kk < 2000) begin @(negedge clk); kk++; end
    chk("midrst_reached", 64'(bitcnt - b0), 64'd20);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_pen", 64'(seg_pen), 64'd1);
    chk("midrst_sclk", 64'(seg_clk), 64'd0);
    chk("midrst_sout", 64'(seg_sout), 64'd0);
    chk("midrst_clrn", 64'(seg_clrn), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("midrst_clrn_rel", 64'(seg_clrn), 64'd1);
    hexs = 32'h89ABCDEF; points = 8'h3C; les = 8'h0F; flash = 1'b1;
    run_frame("post_rst", -10, f);
    chk("post_rst_frame", f, exp_frame(1'b0, 32'h89ABCDEF, 8'h3C, 8'h0F, 1'b1, 64'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
